// File: rtl/pipe_stage_buf.sv
// ----------------------------------------------------------------------------
// pipe_stage_buf
//   Generic pipeline stage register with a valid/ready handshake, hold (stall)
//   and flush control, and a saturating stall-cycle counter. It carries an
//   opaque DATA_WIDTH-bit payload between two pipeline stages.
//
//   Build option: define PIPE_STAGE_SKID_EN to add a second (skid) entry.
//   InReady then comes straight from a register, with no combinational path
//   from OutReady. Without it the stage has a single entry and InReady passes
//   OutReady through combinationally.
//
// Ports
//   Clk                in   rising-edge clock
//   Rst                in   asynchronous active-high reset
//   InValid            in   upstream payload valid
//   InReady            out  stage can accept the upstream payload
//   InData             in   upstream payload
//   OutValid           out  downstream payload valid
//   OutReady           in   downstream accepts the payload
//   OutData            out  downstream payload (main entry register)
//   HoldFlagFromCtrl   in   stall: freeze every entry
//   FlushFlagFromCtrl  in   flush: invalidate every entry (beats hold)
//   Occupancy          out  number of valid entries (0..2)
//   StallCnt           out  saturating count of stalled cycles
// ----------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [DATA_WIDTH-1:0] InData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DATA_WIDTH-1:0] OutData,
    input  logic                  HoldFlagFromCtrl,
    input  logic                  FlushFlagFromCtrl,
    output logic [1:0]            Occupancy,
    output logic [CNT_WIDTH-1:0]  StallCnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                  main_valid;
    logic [DATA_WIDTH-1:0] main_data;
    logic [CNT_WIDTH-1:0]  stall_cnt;
    logic                  gate;
    logic                  in_xfer;
    logic                  out_xfer;

    // Hold or flush blocks both handshakes, so no transfer happens that cycle.
    assign gate     = HoldFlagFromCtrl | FlushFlagFromCtrl;
    assign OutValid = main_valid & ~gate;
    assign OutData  = main_data;
    assign in_xfer  = InValid & InReady;
    assign out_xfer = OutValid & OutReady;
    assign StallCnt = stall_cnt;

`ifdef PIPE_STAGE_SKID_EN
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;

    // Ready depends only on a register, so upstream timing does not see OutReady.
    assign InReady   = ~skid_valid & ~gate;
    assign Occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    // State is implied by the valid bits: EMPTY (none), BUSY (main), FULL (both).
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            main_valid <= 1'b0;
            main_data  <= RESET_VALUE;
            skid_valid <= 1'b0;
            skid_data  <= RESET_VALUE;
        end else if (FlushFlagFromCtrl) begin
            main_valid <= 1'b0;
            main_data  <= RESET_VALUE;
            skid_valid <= 1'b0;
            skid_data  <= RESET_VALUE;
        end else if (!HoldFlagFromCtrl) begin
            if (skid_valid) begin
                // FULL: InReady is low, so only a drain can happen here.
                if (out_xfer) begin
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                end
            end else if (main_valid) begin
                if (in_xfer && out_xfer) begin
                    main_data <= InData;
                end else if (in_xfer) begin
                    skid_data  <= InData;
                    skid_valid <= 1'b1;
                end else if (out_xfer) begin
                    main_valid <= 1'b0;
                end
            end else if (in_xfer) begin
                main_data  <= InData;
                main_valid <= 1'b1;
            end
        end
    end
`else
    // Single entry: a full stage can accept only while it drains.
    assign InReady   = (~main_valid | OutReady) & ~gate;
    assign Occupancy = {1'b0, main_valid};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            main_valid <= 1'b0;
            main_data  <= RESET_VALUE;
        end else if (FlushFlagFromCtrl) begin
            main_valid <= 1'b0;
            main_data  <= RESET_VALUE;
        end else if (!HoldFlagFromCtrl) begin
            if (in_xfer) begin
                main_data  <= InData;
                main_valid <= 1'b1;
            end else if (out_xfer) begin
                main_valid <= 1'b0;
            end
        end
    end
`endif

    // Counts every edge that finds a payload sitting in main without leaving,
    // held cycles included. The flush edge does not count, and flush never
    // clears the counter.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_cnt <= '0;
        end else if (!FlushFlagFromCtrl && main_valid && !out_xfer && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

    localparam logic [63:0] RV  = 64'h13;
    localparam logic [7:0]  RV2 = 8'h13;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        InValid, InReady, OutValid, OutReady, Hold, Flush;
    logic [63:0] InData, OutData;
    logic [1:0]  Occupancy;
    logic [15:0] StallCnt;

    // second instance, narrow counter for saturation
    logic        i2_valid, i2_ready, o2_valid, o2_ready;
    logic [7:0]  i2_data, o2_data;
    logic [1:0]  occ2;
    logic [1:0]  stall2;

    always #5 Clk = ~Clk;

    pipe_stage_buf #(.DATA_WIDTH(64), .RESET_VALUE(RV), .CNT_WIDTH(16)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady), .InData(InData),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
        .HoldFlagFromCtrl(Hold), .FlushFlagFromCtrl(Flush),
        .Occupancy(Occupancy), .StallCnt(StallCnt)
    );

    pipe_stage_buf #(.DATA_WIDTH(8), .RESET_VALUE(RV2), .CNT_WIDTH(2)) dut2 (
        .Clk(Clk), .Rst(Rst), .InValid(i2_valid), .InReady(i2_ready), .InData(i2_data),
        .OutValid(o2_valid), .OutReady(o2_ready), .OutData(o2_data),
        .HoldFlagFromCtrl(1'b0), .FlushFlagFromCtrl(1'b0),
        .Occupancy(occ2), .StallCnt(stall2)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model: a bounded FIFO of payloads ----------------
    logic [63:0] q[$];
    logic [63:0] last_out;   // what the register shows once the FIFO is empty
    int unsigned m_stall;

`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    task automatic model_reset();
        q.delete();
        last_out = RV;
        m_stall  = 0;
    endtask

    // One clock cycle. Called at posedge+1, returns at next posedge+1.
    task automatic cyc(input logic inv, input logic [63:0] d, input logic outr,
                       input logic hold, input logic flush);
        logic gate, e_ir, e_ov, ix, ox;
        int   sz;
        InValid = inv; InData = d; OutReady = outr; Hold = hold; Flush = flush;
        #1;
        sz   = q.size();
        gate = hold | flush;
        if (CAP == 2) e_ir = !gate && sz < 2;
        else          e_ir = !gate && (sz == 0 || outr);
        e_ov = !gate && sz > 0;
        chk("in_ready",  64'(InReady),   64'(e_ir));
        chk("out_valid", 64'(OutValid),  64'(e_ov));
        chk("out_data",  OutData,        (sz > 0) ? q[0] : last_out);
        chk("occupancy", 64'(Occupancy), 64'(sz));
        chk("stall_cnt", 64'(StallCnt),  64'(m_stall));
        ix = inv & e_ir;
        ox = e_ov & outr;
        @(posedge Clk);
        if (flush) begin
            q.delete();
            last_out = RV;
        end else begin
            if (ox) last_out = q.pop_front();
            if (ix) q.push_back(d);
        end
        if (!flush && sz > 0 && !ox && m_stall < 65535) m_stall++;
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        inv;
        logic [63:0] d;
        logic        outr, hold, flush;
        logic        e_ov;     // expected after the edge, inputs still applied
        logic [63:0] e_od;
        logic [1:0]  e_occ;
        logic [15:0] e_stall;
        logic        e_ir;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic inv, logic [63:0] d, logic outr, logic hold, logic flush,
                               logic e_ov, logic [63:0] e_od, logic [1:0] e_occ,
                               logic [15:0] e_stall, logic e_ir);
        vec_t r;
        r.inv = inv; r.d = d; r.outr = outr; r.hold = hold; r.flush = flush;
        r.e_ov = e_ov; r.e_od = e_od; r.e_occ = e_occ; r.e_stall = e_stall; r.e_ir = e_ir;
        return r;
    endfunction

    task automatic run_tbl(input string tag);
        foreach (tbl[i]) begin
            cyc(tbl[i].inv, tbl[i].d, tbl[i].outr, tbl[i].hold, tbl[i].flush);
            chk({tag, "_ov"},    64'(OutValid),  64'(tbl[i].e_ov));
            chk({tag, "_od"},    OutData,        tbl[i].e_od);
            chk({tag, "_occ"},   64'(Occupancy), 64'(tbl[i].e_occ));
            chk({tag, "_stall"}, 64'(StallCnt),  64'(tbl[i].e_stall));
            chk({tag, "_ir"},    64'(InReady),   64'(tbl[i].e_ir));
        end
        tbl.delete();
    endtask

    logic [1:0] sat_exp [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    logic [1:0] occ_full;

    initial begin
        Rst = 1'b1;
        InValid = 0; InData = '0; OutReady = 0; Hold = 0; Flush = 0;
        i2_valid = 0; i2_data = '0; o2_ready = 0;
        occ_full = 2'(CAP);
        model_reset();

        // reset state while Rst is high
        #3;
        chk("rst_ov",    64'(OutValid),  64'(0));
        chk("rst_od",    OutData,        RV);
        chk("rst_occ",   64'(Occupancy), 64'(0));
        chk("rst_stall", 64'(StallCnt),  64'(0));
        chk("rst_ir",    64'(InReady),   64'(1));
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;

        // streaming 1..8 with OutReady=1
        for (int i = 0; i < 8; i++)
            tbl.push_back(v(1, 64'(i + 1), 1, 0, 0, 1, 64'(i + 1), 2'd1, 16'd0, 1));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 64'd8, 2'd0, 16'd0, 1));
        run_tbl("stream");

        // backpressure: A with OutReady=0, then B
        tbl.push_back(v(1, 64'hA, 0, 0, 0, 1, 64'hA, 2'd1,     16'd0, CAP == 2));
        tbl.push_back(v(1, 64'hB, 0, 0, 0, 1, 64'hA, occ_full, 16'd1, 0));
        tbl.push_back(v(1, 64'hB, 1, 0, 0, 1, 64'hB, 2'd1,     16'd1, 1));
        tbl.push_back(v(0, 0,     1, 0, 0, 0, 64'hB, 2'd0,     16'd1, 1));
        run_tbl("bp");

        // asynchronous reset mid-stream (no clock edge between assert and check)
        cyc(1, 64'h55, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        Rst = 1'b1;
        #1;
        chk("arst_ov",    64'(OutValid),  64'(0));
        chk("arst_od",    OutData,        RV);
        chk("arst_occ",   64'(Occupancy), 64'(0));
        chk("arst_stall", 64'(StallCnt),  64'(0));
        @(posedge Clk);
        #1 Rst = 1'b0;
        model_reset();

        // hold 5 cycles with C valid, D presented during hold
        tbl.push_back(v(1, 64'hC, 0, 0, 0, 1, 64'hC, 2'd1, 16'd0, CAP == 2));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(1, 64'hD, 1, 1, 0, 0, 64'hC, 2'd1, 16'(i + 1), 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 64'hC, 2'd0, 16'd5, 1));
        run_tbl("hold");

        // flush together with hold and InValid, from the fullest state
        tbl.push_back(v(1, 64'hE,  0, 0, 0, 1, 64'hE, 2'd1,     16'd5, CAP == 2));
        tbl.push_back(v(1, 64'hF,  0, 0, 0, 1, 64'hE, occ_full, 16'd6, 0));
        tbl.push_back(v(1, 64'h77, 1, 1, 1, 0, RV,    2'd0,     16'd6, 0));
        tbl.push_back(v(0, 0,      1, 0, 0, 0, RV,    2'd0,     16'd6, 1));
        run_tbl("flush");

        // randomized traffic against the FIFO model
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 9) < 6,
                $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0);
        cyc(0, 0, 1, 0, 0);

        // saturation on the 2-bit counter
        chk("sat_start", 64'(stall2), 64'(0));
        i2_valid = 1; i2_data = 8'h5A;
        @(posedge Clk);
        #1 i2_valid = 0;
        chk("sat_occ", 64'(occ2),    64'(1));
        chk("sat_od",  64'(o2_data), 64'(8'h5A));
        for (int k = 0; k < 6; k++) begin
            @(posedge Clk);
            #1 chk("sat_cnt", 64'(stall2), 64'(sat_exp[k]));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register with a valid/ready handshake, stall (hold) and flush control, and a saturating stall-cycle counter. It replaces the fixed-field, hold-only stage registers between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Each instance carries an opaque payload of `DATA_WIDTH` bits. An optional two-entry skid mode gives full throughput with a registered upstream ready.

## Interface
Parameters:
- `DATA_WIDTH`, 64: payload width in bits (≥1).
- `RESET_VALUE`, 0: value loaded into every payload entry on reset and flush.
- `CNT_WIDTH`, 16: width of the stall counter (≥2).

Ports. One clock; reset is asynchronous and active-high.
- `Clk`  in  1  rising-edge clock.
- `Rst`  in  1  asynchronous, active-high reset.
- `InValid`  in  1  upstream payload valid.
- `InReady`  out  1  stage can accept upstream payload.
- `InData`  in  DATA_WIDTH  upstream payload.
- `OutValid`  out  1  downstream payload valid.
- `OutReady`  in  1  downstream accepts payload.
- `OutData`  out  DATA_WIDTH  downstream payload, driven directly from the main entry register.
- `HoldFlagFromCtrl`  in  1  stall request; freezes the stage.
- `FlushFlagFromCtrl`  in  1  flush request; invalidates all entries.
- `Occupancy`  out  2  number of valid entries (0–2).
- `StallCnt`  out  CNT_WIDTH  saturating count of stalled cycles.

## Operation
- Upstream transfer: `InValid & InReady` at the rising edge.
- Downstream transfer: `OutValid & OutReady` at the rising edge.
- Storage: main entry (`MainValid`, `MainData`). With skid mode, a second skid entry (`SkidValid`, `SkidData`).
- States, derived from the valid bits:
  - EMPTY: no entry valid.
  - BUSY: main valid only.
  - FULL: main and skid valid (skid mode only).
- Gating: `InReady` and `OutValid` are both forced 0 while `HoldFlagFromCtrl` or `FlushFlagFromCtrl` is 1. No transfer occurs in that cycle.
- Ungated values:
  - `OutValid = MainValid`.
  - `InReady` is defined under Configuration.
- Transitions with skid mode (ungated cycles):
  - EMPTY + in-transfer → BUSY; `MainData <= InData`.
  - BUSY + in-transfer + out-transfer → BUSY; main is replaced by `InData`.
  - BUSY + in-transfer, no out-transfer → FULL; `SkidData <= InData`.
  - BUSY + out-transfer only → EMPTY.
  - FULL + out-transfer → BUSY; main <= skid, skid invalidated. No in-transfer is possible in FULL.
- Hold: all entries, valid bits and data are retained unchanged.
- Flush:
  - All valid bits are cleared and all data loaded with `RESET_VALUE` at the next edge.
  - Flush has priority over hold and over any pending transfer.
- Payload ordering: strictly FIFO. No payload is ever dropped or duplicated except by flush.
- Stall counter:
  - Increments by 1 on every edge where `MainValid=1` and no downstream transfer occurs. This includes held cycles, but excludes the flush cycle itself.
  - Saturates at all-ones and does not wrap.
  - Cleared only by `Rst`; flush does not affect it.
- `Occupancy` equals `MainValid + SkidValid`.

## Timing
- Reset: asynchronous, active-high. While `Rst=1` and on release:
  - `OutValid=0`, `Occupancy=0`, `StallCnt=0`.
  - `OutData=RESET_VALUE`, skid entry invalid.
  - `InReady=1` unless hold or flush is asserted.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Latency: payload accepted at edge N appears on `OutData` with `OutValid=1` after edge N (1 cycle) when the stage was EMPTY or drained in the same cycle.
- Throughput: one payload per cycle while `OutReady=1` and no hold or flush.
- `OutData` is registered. With skid mode, `InReady` is also registered (it depends only on `SkidValid` plus the combinational hold/flush gate).
- Release of hold: transfers resume in the first cycle in which `HoldFlagFromCtrl=0`.

## Configuration
- Macro `PIPE_STAGE_SKID_EN`.
- Defined:
  - Skid entry present; FULL state reachable; `Occupancy` can reach 2.
  - Ungated `InReady = ~SkidValid`, so there is no combinational path from `OutReady` to `InReady`.
- Undefined:
  - Single entry; the skid entry and FULL state are absent; `Occupancy` is at most 1.
  - Ungated `InReady = ~MainValid | OutReady`, a combinational pass-through.
  - BUSY + in-transfer without out-transfer cannot occur.
- Hold, flush, counter and reset behaviour are identical in both builds.

## Test plan
- Reset: hold `Rst=1` mid-stream with `DATA_WIDTH=64`, `RESET_VALUE=64'h13` → all of the following, asynchronously:
  - `OutValid=0`, `OutData=64'h13`, `Occupancy=0`, `StallCnt=0`.
- Streaming: drive 8 back-to-back payloads 1..8 with `OutReady=1` → all of the following:
  - `OutData` shows 1..8 on consecutive cycles, each one cycle after its input.
  - `StallCnt` stays 0.
- Backpressure:
  - Skid build: accept A with `OutReady=0`, then present B. Result: B is accepted, `Occupancy=2`, `InReady=0`. Raising `OutReady` delivers A then B.
  - Non-skid build: in the same sequence B is refused until A leaves.
- Hold: assert hold for 5 cycles with A valid → `OutValid=0` and `InReady=0` during the hold, `StallCnt=5`. A is delivered after release.
- Flush priority: assert flush together with hold and `InValid=1` in state FULL → next cycle all of the following:
  - `Occupancy=0` and `OutData=RESET_VALUE`; the input is not accepted.
  - `StallCnt` unchanged.
- Saturation: with `CNT_WIDTH=2`, stall for 6 cycles → `StallCnt` reads 1, 2, 3, 3, 3, 3.
